// File: rtl/sq_sum_terms_pipe.sv
// sq_sum_terms_pipe
// -----------------
// Pipelined multi-operand summation for the MSU squaring datapath. Each
// accepted beat carries NumTerms unsigned column terms. The terms are
// registered, reduced by a zero-padded binary adder tree with a register
// stage after every LevelsPerStage levels, and then folded into an
// accumulator. A beat with last_i set closes its group and publishes the
// group sum together with a sticky wrap flag.
//
// Ports
//   clk_i       clock
//   rst_ni      synchronous active-low reset
//   terms_i     NumTerms x TermBits input terms
//   valid_i     input beat valid
//   last_i      input beat closes the current accumulation group
//   ready_o     input beat accepted when valid_i && ready_o
//   sum_o       group sum (modulo 2^SumBits)
//   overflow_o  group sum wrapped at least once, qualified by valid_o
//   valid_o     result valid
//   ready_i     downstream accepts the result
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. valid_o/sum_o/overflow_o never change while valid_o=1 and
// ready_i=0. The whole pipeline advances on one shared enable
// (en = !valid_o || ready_i), and ready_o is that enable, so the pipeline
// freezes as a unit under backpressure and no beat is dropped or repeated.
module sq_sum_terms_pipe #(
  parameter int unsigned NumTerms       = 16,
  parameter int unsigned TermBits       = 32,
  parameter int unsigned SumBits        = 40,
  parameter int unsigned LevelsPerStage = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [TermBits-1:0] terms_i [NumTerms],
  input  logic                valid_i,
  input  logic                last_i,
  output logic                ready_o,
  output logic [SumBits-1:0]  sum_o,
  output logic                overflow_o,
  output logic                valid_o,
  input  logic                ready_i
);

  localparam int unsigned Levels = $clog2(NumTerms);
  localparam int unsigned Leaves = 1 << Levels;
  localparam int unsigned Stages = (Levels + LevelsPerStage - 1) / LevelsPerStage;

  // Parameter sanity checks at elaboration time.
  if (NumTerms < 2) begin : g_err_terms
    $error("sq_sum_terms_pipe: NumTerms must be at least 2");
  end
  if (SumBits < TermBits + $clog2(NumTerms)) begin : g_err_width
    $error("sq_sum_terms_pipe: SumBits too narrow for a tree sum without overflow");
  end
  if ((LevelsPerStage < 1) || (LevelsPerStage > Levels)) begin : g_err_lps
    $error("sq_sum_terms_pipe: LevelsPerStage must be in 1..Levels");
  end

  logic en_w;
  assign en_w    = !valid_o || ready_i;
  assign ready_o = en_w;

  // node_w[l] is the combinational output of tree level l (level 0 are the
  // zero-extended leaves); src_w[l] is what level l+1 consumes, i.e. the
  // registered copy where level l ends a pipeline stage.
  logic [SumBits-1:0] node_w [Levels+1][Leaves];
  logic [SumBits-1:0] src_w  [Levels+1][Leaves];

  for (genvar l = 0; l <= Levels; l++) begin : g_lvl
    // Level 0 is the input register; after that a register closes every
    // LevelsPerStage levels, and the final level always ends in a register.
    localparam bit IsReg = ((l % LevelsPerStage) == 0) || (l == Levels);
    for (genvar i = 0; i < Leaves; i++) begin : g_node
      if (i < (Leaves >> l)) begin : g_live
        if (l == 0) begin : g_leaf
          if (i < NumTerms) begin : g_term
            assign node_w[l][i] = SumBits'(terms_i[i]);
          end else begin : g_pad
            assign node_w[l][i] = '0;
          end
        end else begin : g_add
          assign node_w[l][i] = src_w[l-1][2*i] + src_w[l-1][2*i+1];
        end
        if (IsReg) begin : g_reg
          logic [SumBits-1:0] node_q;
          // Data needs no reset: it is only consumed when its valid bit is set.
          always_ff @(posedge clk_i) begin
            if (en_w) begin
              node_q <= node_w[l][i];
            end
          end
          assign src_w[l][i] = node_q;
        end else begin : g_comb
          assign src_w[l][i] = node_w[l][i];
        end
      end else begin : g_dead
        assign node_w[l][i] = '0;
        assign src_w[l][i]  = '0;
      end
    end
  end

  // Valid/last shadow of the data registers: index 0 is the input register,
  // index Stages is the tree output register.
  logic [Stages:0] vld_q;
  logic [Stages:0] lst_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_q <= '0;
      lst_q <= '0;
    end else if (en_w) begin
      vld_q <= {vld_q[Stages-1:0], valid_i};
      lst_q <= {lst_q[Stages-1:0], last_i};
    end
  end

  logic               tree_vld_w;
  logic               tree_lst_w;
  logic [SumBits-1:0] tree_w;
  assign tree_vld_w = vld_q[Stages];
  assign tree_lst_w = lst_q[Stages];
  assign tree_w     = src_w[Levels][0];

  // Accumulator and result registers.
  logic [SumBits-1:0] acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic               first_q, first_d;
  logic [SumBits-1:0] sum_q, sum_d;
  logic               ovfo_q, ovfo_d;
  logic               valid_q, valid_d;

  logic [SumBits-1:0] base_w;
  logic [SumBits:0]   add_w;
  logic               novf_w;

  always_comb begin
    // The first beat of a group starts from zero regardless of acc_q/ovf_q.
    base_w = first_q ? '0 : acc_q;
    add_w  = {1'b0, base_w} + {1'b0, tree_w};
    novf_w = (!first_q && ovf_q) || add_w[SumBits];
  end

  always_comb begin
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    first_d = first_q;
    sum_d   = sum_q;
    ovfo_d  = ovfo_q;
    valid_d = valid_q;
    if (en_w) begin
      // With en high any previous result was consumed or never there.
      valid_d = 1'b0;
      if (tree_vld_w) begin
        if (tree_lst_w) begin
          sum_d   = add_w[SumBits-1:0];
          ovfo_d  = novf_w;
          valid_d = 1'b1;
          first_d = 1'b1;
          acc_d   = '0;
          ovf_d   = 1'b0;
        end else begin
          acc_d   = add_w[SumBits-1:0];
          ovf_d   = novf_w;
          first_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      first_q <= 1'b1;
      sum_q   <= '0;
      ovfo_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      first_q <= first_d;
      sum_q   <= sum_d;
      ovfo_q  <= ovfo_d;
      valid_q <= valid_d;
    end
  end

  assign sum_o      = sum_q;
  assign overflow_o = ovfo_q;
  assign valid_o    = valid_q;

endmodule

// File: tb/tb_sq_sum_terms_pipe.sv
// Testbench for sq_sum_terms_pipe: default instance (16 x 32 -> 40, LPS 2),
// a narrow instance that can wrap (16 x 8 -> 12) and an odd-width tree
// (5 terms, LPS 1). Results of the default instance are scored against a
// group-sum model fed from accepted beats.
module tb_sq_sum_terms_pipe;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance
  logic [31:0] t0 [16];
  logic        v0, l0, ri0, r0, o0, vo0;
  logic [39:0] s0;

  // Narrow instance that can overflow
  logic [7:0]  t1 [16];
  logic        v1, l1, ri1, r1, o1, vo1;
  logic [11:0] s1;

  // Odd tree instance
  logic [31:0] t2 [5];
  logic        v2, l2, ri2, r2, o2, vo2;
  logic [39:0] s2;

  sq_sum_terms_pipe #(.NumTerms(16), .TermBits(32), .SumBits(40), .LevelsPerStage(2)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .terms_i(t0), .valid_i(v0), .last_i(l0), .ready_o(r0),
    .sum_o(s0), .overflow_o(o0), .valid_o(vo0), .ready_i(ri0));

  sq_sum_terms_pipe #(.NumTerms(16), .TermBits(8), .SumBits(12), .LevelsPerStage(2)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .terms_i(t1), .valid_i(v1), .last_i(l1), .ready_o(r1),
    .sum_o(s1), .overflow_o(o1), .valid_o(vo1), .ready_i(ri1));

  sq_sum_terms_pipe #(.NumTerms(5), .TermBits(32), .SumBits(40), .LevelsPerStage(1)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .terms_i(t2), .valid_i(v2), .last_i(l2), .ready_o(r2),
    .sum_o(s2), .overflow_o(o2), .valid_o(vo2), .ready_i(ri2));

  int n_vec = 0;
  int n_err = 0;
  int hs0   = 0;

  // Scoreboard for the default instance: {overflow, sum} per closed group.
  logic [40:0] exp_q[$];
  logic [63:0] grp = '0;
  logic [40:0] ent;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      grp = '0;
    end else begin
      if (vo0 && ri0) begin
        hs0++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected: got sum=%0d ovf=%0b, required no result", s0, o0);
        end else begin
          ent = exp_q.pop_front();
          if ({o0, s0} !== ent) begin
            n_err++;
            $display("FAIL sb_result: got sum=%0d ovf=%0b, required sum=%0d ovf=%0b",
                     s0, o0, ent[39:0], ent[40]);
          end
        end
      end
      if (v0 && r0) begin
        for (int j = 0; j < 16; j++) grp += 64'(t0[j]);
        if (l0) begin
          ent[39:0] = grp[39:0];
          ent[40]   = (grp >> 40) != 0;
          exp_q.push_back(ent);
          grp = '0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send0();
    logic took;
    took = 1'b0;
    v0 = 1'b1;
    for (int k = 0; k < 100 && !took; k++) begin
      @(negedge clk);
      took = r0;
      @(posedge clk);
      #1;
    end
    v0 = 1'b0;
    n_vec++;
    if (!took) begin
      n_err++;
      $display("FAIL send0_timeout: got no accept, required accept");
    end
  endtask

  task automatic send1();
    logic took;
    took = 1'b0;
    v1 = 1'b1;
    for (int k = 0; k < 100 && !took; k++) begin
      @(negedge clk);
      took = r1;
      @(posedge clk);
      #1;
    end
    v1 = 1'b0;
    n_vec++;
    if (!took) begin
      n_err++;
      $display("FAIL send1_timeout: got no accept, required accept");
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_vec++;
    if (vo0 !== 1'b0 || s0 !== 40'd0 || o0 !== 1'b0 || r0 !== 1'b1) begin
      n_err++;
      $display("FAIL reset_dut0: got v=%0b s=%0d o=%0b r=%0b, required 0 0 0 1", vo0, s0, o0, r0);
    end
    n_vec++;
    if (vo1 !== 1'b0 || s1 !== 12'd0 || r1 !== 1'b1 || vo2 !== 1'b0 || s2 !== 40'd0 || r2 !== 1'b1) begin
      n_err++;
      $display("FAIL reset_others: got v1=%0b s1=%0d r1=%0b v2=%0b s2=%0d r2=%0b, required 0 0 1 0 0 1",
               vo1, s1, r1, vo2, s2, r2);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_beat();
    int lat;
    logic [39:0] sum_at;
    logic ovf_at, next_v;
    int exp_lat;
    exp_lat = (($clog2(16) + 1) / 2) + 1;
    lat = -1;
    sum_at = '0;
    ovf_at = 1'b1;
    next_v = 1'b1;
    ri0 = 1'b1;
    for (int j = 0; j < 16; j++) t0[j] = 32'd1;
    l0 = 1'b1;
    v0 = 1'b1;
    @(negedge clk);
    n_vec++;
    if (r0 !== 1'b1) begin
      n_err++;
      $display("FAIL single_ready: got %0b, required 1", r0);
    end
    @(posedge clk);
    #1;
    v0 = 1'b0;
    l0 = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (lat < 0 && vo0) begin
        lat = c;
        sum_at = s0;
        ovf_at = o0;
      end else if (lat > 0 && c == lat + 1) begin
        next_v = vo0;
      end
    end
    n_vec++;
    if (lat != exp_lat) begin
      n_err++;
      $display("FAIL single_latency: got %0d, required %0d", lat, exp_lat);
    end
    n_vec++;
    if (sum_at !== 40'd16 || ovf_at !== 1'b0) begin
      n_err++;
      $display("FAIL single_sum: got sum=%0d ovf=%0b, required 16 0", sum_at, ovf_at);
    end
    n_vec++;
    if (next_v !== 1'b0) begin
      n_err++;
      $display("FAIL single_valid_drop: got %0b, required 0", next_v);
    end
  endtask

  task automatic test_multi_beat();
    int h_before;
    logic found;
    logic [39:0] got;
    int exp_sum;
    h_before = hs0;
    exp_sum = 0;
    found = 1'b0;
    got = '0;
    ri0 = 1'b1;
    for (int b = 0; b < 3; b++) begin
      for (int j = 0; j < 16; j++) begin
        t0[j] = 32'(j);
        exp_sum += j;
      end
      l0 = (b == 2);
      send0();
      l0 = 1'b0;
      if (b < 2) begin
        tick();
        tick();
      end
    end
    for (int k = 0; k < 10 && !found; k++) begin
      tick();
      if (vo0) begin
        found = 1'b1;
        got = s0;
      end
    end
    n_vec++;
    if (!found || got !== 40'(exp_sum)) begin
      n_err++;
      $display("FAIL multi_sum: got found=%0b sum=%0d, required sum=%0d", found, got, exp_sum);
    end
    tick();
    tick();
    n_vec++;
    if (hs0 - h_before != 1) begin
      n_err++;
      $display("FAIL multi_count: got %0d results, required 1", hs0 - h_before);
    end
  endtask

  task automatic test_backpressure();
    int h_before;
    h_before = hs0;
    ri0 = 1'b1;
    fork
      begin
        for (int g = 0; g < 6; g++) begin
          for (int j = 0; j < 16; j++) t0[j] = 32'(g + 1);
          l0 = 1'b1;
          send0();
          l0 = 1'b0;
        end
      end
      begin
        logic found;
        logic [39:0] held;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
          tick();
          if (vo0) found = 1'b1;
        end
        n_vec++;
        if (!found) begin
          n_err++;
          $display("FAIL bp_wait: got no valid_o, required valid_o");
        end else begin
          ri0 = 1'b0;
          held = s0;
          n_vec++;
          if (held !== 40'd16) begin
            n_err++;
            $display("FAIL bp_first: got %0d, required 16", held);
          end
          for (int k = 0; k < 5; k++) begin
            tick();
            n_vec++;
            if (s0 !== held || vo0 !== 1'b1 || r0 !== 1'b0) begin
              n_err++;
              $display("FAIL bp_hold: got s=%0d v=%0b r=%0b, required s=%0d v=1 r=0", s0, vo0, r0, held);
            end
          end
          ri0 = 1'b1;
        end
      end
    join
    for (int k = 0; k < 12; k++) tick();
    n_vec++;
    if (hs0 - h_before != 6) begin
      n_err++;
      $display("FAIL bp_count: got %0d results, required 6", hs0 - h_before);
    end
  endtask

  task automatic test_reset_mid_group();
    logic found;
    found = 1'b0;
    ri0 = 1'b1;
    for (int b = 0; b < 2; b++) begin
      for (int j = 0; j < 16; j++) t0[j] = $urandom();
      l0 = 1'b0;
      send0();
    end
    rst_n = 1'b0;
    tick();
    n_vec++;
    if (vo0 !== 1'b0 || s0 !== 40'd0 || r0 !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_during: got v=%0b s=%0d r=%0b, required 0 0 1", vo0, s0, r0);
    end
    rst_n = 1'b1;
    tick();
    n_vec++;
    if (vo0 !== 1'b0 || s0 !== 40'd0 || r0 !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_after: got v=%0b s=%0d r=%0b, required 0 0 1", vo0, s0, r0);
    end
    for (int j = 0; j < 16; j++) t0[j] = 32'd1;
    l0 = 1'b1;
    send0();
    l0 = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      tick();
      if (vo0) found = 1'b1;
    end
    n_vec++;
    if (!found || s0 !== 40'd16 || o0 !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_result: got found=%0b sum=%0d ovf=%0b, required 16 0", found, s0, o0);
    end
    tick();
  endtask

  task automatic test_random();
    logic took;
    int beats;
    beats = 0;
    took = 1'b0;
    v0 = 1'b0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      if (took || !v0) begin
        v0 = ($urandom_range(0, 3) != 0);
        if (cyc < 350) begin
          for (int j = 0; j < 16; j++) t0[j] = $urandom();
          l0 = ($urandom_range(0, 3) == 0);
        end else begin
          // Long groups of all-ones terms push the 40-bit sum past its range.
          for (int j = 0; j < 16; j++) t0[j] = 32'hFFFF_FFFF;
          l0 = v0 && ((beats % 20) == 19);
          if (v0) beats++;
        end
      end
      ri0 = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      took = v0 && r0;
      @(posedge clk);
      #1;
    end
    v0 = 1'b0;
    l0 = 1'b0;
    ri0 = 1'b1;
    for (int k = 0; k < 20; k++) tick();
  endtask

  task automatic test_overflow();
    logic found;
    int tot;
    int exp_sum;
    logic exp_ovf;
    ri1 = 1'b1;
    tot = 0;
    for (int b = 0; b < 2; b++) begin
      for (int j = 0; j < 16; j++) begin
        t1[j] = 8'hFF;
        tot += 255;
      end
      l1 = (b == 1);
      send1();
      l1 = 1'b0;
    end
    exp_sum = tot % 4096;
    exp_ovf = (tot >= 4096);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      tick();
      if (vo1) found = 1'b1;
    end
    n_vec++;
    if (!found || s1 !== 12'(exp_sum) || o1 !== exp_ovf) begin
      n_err++;
      $display("FAIL ovf_wrap: got found=%0b sum=%0d ovf=%0b, required sum=%0d ovf=%0b",
               found, s1, o1, exp_sum, exp_ovf);
    end
    for (int j = 0; j < 16; j++) t1[j] = 8'd1;
    l1 = 1'b1;
    send1();
    l1 = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      tick();
      if (vo1) found = 1'b1;
    end
    n_vec++;
    if (!found || s1 !== 12'd16 || o1 !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_clear: got found=%0b sum=%0d ovf=%0b, required 16 0", found, s1, o1);
    end
    tick();
  endtask

  task automatic test_odd_tree();
    int lat;
    int exp_lat;
    int exp_sum;
    logic [39:0] sum_at;
    exp_lat = $clog2(5) + 1;
    exp_sum = 0;
    lat = -1;
    sum_at = '0;
    ri2 = 1'b1;
    for (int j = 0; j < 5; j++) begin
      t2[j] = 32'(j + 1);
      exp_sum += j + 1;
    end
    l2 = 1'b1;
    v2 = 1'b1;
    @(negedge clk);
    n_vec++;
    if (r2 !== 1'b1) begin
      n_err++;
      $display("FAIL odd_ready: got %0b, required 1", r2);
    end
    @(posedge clk);
    #1;
    v2 = 1'b0;
    l2 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (lat < 0 && vo2) begin
        lat = c;
        sum_at = s2;
      end
    end
    n_vec++;
    if (lat != exp_lat || sum_at !== 40'(exp_sum) || o2 !== 1'b0) begin
      n_err++;
      $display("FAIL odd_tree: got lat=%0d sum=%0d ovf=%0b, required lat=%0d sum=%0d ovf=0",
               lat, sum_at, o2, exp_lat, exp_sum);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    v0 = 1'b0; l0 = 1'b0; ri0 = 1'b0;
    v1 = 1'b0; l1 = 1'b0; ri1 = 1'b0;
    v2 = 1'b0; l2 = 1'b0; ri2 = 1'b0;
    for (int j = 0; j < 16; j++) begin
      t0[j] = '0;
      t1[j] = '0;
    end
    for (int j = 0; j < 5; j++) t2[j] = '0;
    #1;
    test_reset();
    test_single_beat();
    test_multi_beat();
    test_backpressure();
    test_reset_mid_group();
    test_random();
    test_overflow();
    test_odd_tree();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: got %0d pending, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
